// File: rtl/instr_exec_sequencer.sv
// Batch sequencer that walks the instruction register, executes each opcode on
// two signed operands and hands results downstream over a valid/ready port.
module instr_exec_sequencer #(
  parameter  int DEPTH = 32,
  parameter  int OPW   = 32,
  parameter  int RW    = 64,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_en,
  input  logic                 start,
  input  logic [IW-1:0]        first_index,
  input  logic [IW:0]          count,
  output logic [IW-1:0]        read_index,
  input  logic [4+2*OPW-1:0]   instruction,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [RW-1:0]        result,
  output logic [IW-1:0]        res_index,
  output logic [3:0]           res_opcode,
  output logic                 div_err,
  output logic                 op_err,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_OUT   = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
  localparam logic [IW:0]   ONE_CNT  = (IW+1)'(1);

  state_e               state_q;
  logic [IW-1:0]        ptr_q;
  logic [IW:0]          rem_q;
  logic [4+2*OPW-1:0]   instr_q;
  logic                 armed_q;
  logic                 res_valid_q;
  logic [RW-1:0]        result_q;
  logic [IW-1:0]        res_index_q;
  logic [3:0]           res_opcode_q;
  logic                 div_err_q;
  logic                 op_err_q;
  logic                 busy_q;
  logic                 done_q;

  logic [3:0]           opcode_s;
  logic signed [RW-1:0] a_ext_s;
  logic signed [RW-1:0] b_ext_s;
  logic                 b_zero_s;
  logic [IW-1:0]        ptr_next_s;
  logic [RW-1:0]        alu_result_d;
  logic                 div_err_d;
  logic                 op_err_d;

  // Decode the registered instruction and sign-extend both operands to RW.
  always_comb begin
    opcode_s = instr_q[4+2*OPW-1 -: 4];
    a_ext_s  = {{(RW-OPW){instr_q[2*OPW-1]}}, instr_q[2*OPW-1:OPW]};
    b_ext_s  = {{(RW-OPW){instr_q[OPW-1]}}, instr_q[OPW-1:0]};
    b_zero_s = (instr_q[OPW-1:0] == {OPW{1'b0}});
    if (ptr_q == LAST_IDX) begin
      ptr_next_s = {IW{1'b0}};
    end else begin
      ptr_next_s = ptr_q + IW'(1);
    end
  end

  // Execute the opcode; divide-by-zero and unknown opcodes force a zero result.
  always_comb begin
    alu_result_d = {RW{1'b0}};
    div_err_d    = 1'b0;
    op_err_d     = 1'b0;
    case (opcode_s)
      4'd0: alu_result_d = {RW{1'b0}};
      4'd1: alu_result_d = a_ext_s;
      4'd2: alu_result_d = b_ext_s;
      4'd3: alu_result_d = a_ext_s + b_ext_s;
      4'd4: alu_result_d = a_ext_s - b_ext_s;
      4'd5: alu_result_d = a_ext_s * b_ext_s;
      4'd6: begin
        if (b_zero_s) begin
          div_err_d    = 1'b1;
          alu_result_d = {RW{1'b0}};
        end else begin
          alu_result_d = a_ext_s / b_ext_s;
        end
      end
      4'd7: begin
        if (b_zero_s) begin
          div_err_d    = 1'b1;
          alu_result_d = {RW{1'b0}};
        end else begin
          alu_result_d = a_ext_s % b_ext_s;
        end
      end
      default: begin
        op_err_d     = 1'b1;
        alu_result_d = {RW{1'b0}};
      end
    endcase
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_en) begin
    if (!reset_en) begin
      state_q      <= S_IDLE;
      ptr_q        <= {IW{1'b0}};
      rem_q        <= {(IW+1){1'b0}};
      instr_q      <= {(4+2*OPW){1'b0}};
      armed_q      <= 1'b0;
      res_valid_q  <= 1'b0;
      result_q     <= {RW{1'b0}};
      res_index_q  <= {IW{1'b0}};
      res_opcode_q <= 4'd0;
      div_err_q    <= 1'b0;
      op_err_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // armed_q masks a start that coincides with the reset-release edge.
      armed_q <= 1'b1;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (start && armed_q) begin
            if (count != {(IW+1){1'b0}}) begin
              ptr_q   <= first_index;
              rem_q   <= count;
              busy_q  <= 1'b1;
              state_q <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          instr_q <= instruction;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          result_q     <= alu_result_d;
          div_err_q    <= div_err_d;
          op_err_q     <= op_err_d;
          res_opcode_q <= opcode_s;
          res_index_q  <= ptr_q;
          res_valid_q  <= 1'b1;
          state_q      <= S_OUT;
        end
        S_OUT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (rem_q > ONE_CNT) begin
              ptr_q   <= ptr_next_s;
              rem_q   <= rem_q - ONE_CNT;
              state_q <= S_FETCH;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q      <= 1'b0;
          res_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign read_index = ptr_q;
  assign res_valid  = res_valid_q;
  assign result     = result_q;
  assign res_index  = res_index_q;
  assign res_opcode = res_opcode_q;
  assign div_err    = div_err_q;
  assign op_err     = op_err_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
